// File: rtl/clk_mult_ratio_ctrl_pkg.sv
// Shared types for the clock-doubler ratio controller: FSM state encoding
// and the ratio codes understood by the doubler output mux.
package clk_mult_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    RST      = 3'd2,
    SETTLE   = 3'd3,
    GATE_ON  = 3'd4
  } state_e;

  localparam logic [1:0] RATIO_1X  = 2'd0;
  localparam logic [1:0] RATIO_2X  = 2'd1;
  localparam logic [1:0] RATIO_4X  = 2'd2;
  localparam logic [1:0] RATIO_BAD = 2'd3;

endpackage

// File: rtl/clk_mult_ratio_ctrl_if.sv
// Request/status bundle between a ratio requester and clk_mult_ratio_ctrl.
interface clk_mult_ratio_ctrl_if;

  // Handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both high. req_ready is high only while the controller is
  // idle; a requester must hold req_valid and req_ratio stable until then.
  logic       req_valid;
  logic [1:0] req_ratio;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] cur_ratio;

  modport master (
    output req_valid, req_ratio,
    input  req_ready, busy, done, err, cur_ratio
  );

  modport slave (
    input  req_valid, req_ratio,
    output req_ready, busy, done, err, cur_ratio
  );

endinterface

// File: rtl/clk_mult_ratio_ctrl_timer.sv
// Loadable phase down-counter shared by all sequencing phases. A load of 0
// is treated as 1 so every phase lasts at least one cycle.
module clk_seq_timer #(
  parameter int unsigned          CNT_W   = 4,
  parameter logic [CNT_W-1:0]     RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LOAD = (RST_VAL == '0) ? ONE : RST_VAL;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val == '0) ? ONE : load_val;
    end else if (count_q > ONE) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_LOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == ONE);

endmodule

// File: rtl/clk_mult_ratio_ctrl.sv
// Sequences glitch-safe ratio changes of the XOR clock-doubler chain:
// gate off, hold toggle flops in reset, switch mux, release, settle, gate on.
module clk_mult_ratio_ctrl
  import clk_mult_pkg::*;
#(
  parameter int unsigned GATE_CYC   = 4,
  parameter int unsigned RST_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CNT_W      = 4,
  parameter logic [1:0]  INIT_RATIO = 2'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clk_mult_ratio_ctrl_if.slave  req_if,
  output logic [1:0]            mult_sel,
  output logic                  mult_rst_n,
  output logic                  clk_gate_en,
  output state_e                dbg_state
);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

  state_e     state_q, state_d;
  logic [1:0] pending_q, pending_d;
  logic [1:0] mult_sel_q, mult_sel_d;
  logic [1:0] cur_ratio_q, cur_ratio_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       req_ready_q, req_ready_d;
  logic       busy_q, busy_d;
  logic       gate_en_q, gate_en_d;
  logic       mult_rst_n_q, mult_rst_n_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;

  // Reset leaves the timer preloaded for the RST phase of power-up.
  clk_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    mult_sel_d  = mult_sel_q;
    cur_ratio_d = cur_ratio_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = GATE_LD;

    case (state_q)
      IDLE: begin
        if (req_if.req_valid && req_ready_q) begin
          if (req_if.req_ratio == RATIO_BAD) begin
            err_d = 1'b1;
          end else if (req_if.req_ratio == cur_ratio_q) begin
            done_d = 1'b1;
          end else begin
            pending_d = req_if.req_ratio;
            state_d   = GATE_OFF;
            tmr_load  = 1'b1;
            tmr_val   = GATE_LD;
          end
        end
      end
      GATE_OFF: begin
        // The mux switches on the same edge the toggle flops enter reset.
        if (tmr_expire) begin
          state_d    = RST;
          mult_sel_d = pending_q;
          tmr_load   = 1'b1;
          tmr_val    = RST_LD;
        end
      end
      RST: begin
        if (tmr_expire) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (tmr_expire) begin
          state_d     = GATE_ON;
          cur_ratio_d = mult_sel_q;
          done_d      = 1'b1;
        end
      end
      GATE_ON: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    gate_en_d    = (state_d == IDLE) || (state_d == GATE_ON);
    mult_rst_n_d = (state_d != RST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST;
      pending_q    <= INIT_RATIO;
      mult_sel_q   <= INIT_RATIO;
      cur_ratio_q  <= INIT_RATIO;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
      gate_en_q    <= 1'b0;
      mult_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mult_sel_q   <= mult_sel_d;
      cur_ratio_q  <= cur_ratio_d;
      done_q       <= done_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      gate_en_q    <= gate_en_d;
      mult_rst_n_q <= mult_rst_n_d;
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.busy      = busy_q;
  assign req_if.done      = done_q;
  assign req_if.err       = err_q;
  assign req_if.cur_ratio = cur_ratio_q;
  assign mult_sel         = mult_sel_q;
  assign mult_rst_n       = mult_rst_n_q;
  assign clk_gate_en      = gate_en_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_clk_mult_ratio_ctrl.sv
// Directed bench for clk_mult_ratio_ctrl: per-cycle expected output vectors
// are queued from hand-derived timelines and compared cycle by cycle.
module tb_clk_mult_ratio_ctrl;
  import clk_mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clk_mult_ratio_ctrl_if rif ();

  logic [1:0] mult_sel;
  logic       mult_rst_n;
  logic       clk_gate_en;
  state_e     dbg_state;

  clk_mult_ratio_ctrl #(
    .GATE_CYC   (4),
    .RST_CYC    (2),
    .SETTLE_CYC (8),
    .CNT_W      (4),
    .INIT_RATIO (2'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (rif.slave),
    .mult_sel    (mult_sel),
    .mult_rst_n  (mult_rst_n),
    .clk_gate_en (clk_gate_en),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Vector layout: {gate, mult_rst_n, mult_sel[1:0], cur_ratio[1:0], done, err, ready, busy}
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic g, input logic r, input logic [1:0] s,
                                    input logic [1:0] c, input logic d, input logic e,
                                    input logic rdy, input logic b);
    return {g, r, s, c, d, e, rdy, b};
  endfunction

  function automatic logic [9:0] obs();
    return {clk_gate_en, mult_rst_n, mult_sel, rif.cur_ratio, rif.done, rif.err,
            rif.req_ready, rif.busy};
  endfunction

  localparam logic [9:0] RST_VEC = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Power-up timeline, cycle k = k edges after rst_n release.
  task automatic push_powerup();
    for (int k = 1; k <= 11; k++)
      exp_q.push_back(mk(k >= 10, k >= 2, 2'd0, 2'd0, k == 10, 1'b0, k >= 11, k < 11));
  endtask

  // Ratio-change timeline, cycle 1 = first cycle after the accept edge.
  task automatic push_change(input logic [1:0] old_r, input logic [1:0] new_r, input int n);
    for (int k = 1; k <= n; k++)
      exp_q.push_back(mk(k > 14, !(k == 5 || k == 6), (k >= 5) ? new_r : old_r,
                         (k >= 15) ? new_r : old_r, k == 15, 1'b0, k >= 16, k < 16));
  endtask

  task automatic run_n(input string tag, input int n);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk({tag, "_underrun"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_c%0d", tag, i + 1), 32'(obs()), 32'(e));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input logic v, input logic [1:0] r);
    rif.req_valid = v;
    rif.req_ratio = r;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_req(1'b0, 2'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vec", 32'(obs()), 32'(RST_VEC));
    chk("reset_state", 32'(dbg_state), 32'(RST));

    // Power-up to INIT_RATIO
    rst_n = 1'b1;
    push_powerup();
    run_n("pwrup", 11);
    chk("pwrup_state", 32'(dbg_state), 32'(IDLE));

    // Illegal ratio: err next cycle, nothing else moves
    drive_req(1'b1, 2'd3);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    run_n("bad", 1);
    drive_req(1'b0, 2'd0);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_n("bad_after", 1);

    // Same ratio: done next cycle, no gating
    drive_req(1'b1, 2'd0);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    run_n("same", 1);
    drive_req(1'b0, 2'd0);
    exp_q.push_back(mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_n("same_after", 1);

    // 1x -> 4x, then a held 2x request raised while busy
    drive_req(1'b1, 2'd2);
    push_change(2'd0, 2'd2, 16);
    run_n("to4x", 1);
    drive_req(1'b1, 2'd1);
    run_n("to4x_busy", 15);
    push_change(2'd2, 2'd1, 16);
    run_n("to2x", 1);
    drive_req(1'b0, 2'd0);
    run_n("to2x_rest", 15);
    chk("to2x_cur", 32'(rif.cur_ratio), 32'd1);

    // 2x -> 4x interrupted by reset during SETTLE
    drive_req(1'b1, 2'd2);
    push_change(2'd1, 2'd2, 9);
    run_n("abort", 1);
    drive_req(1'b0, 2'd0);
    run_n("abort_run", 8);
    chk("abort_in_settle", 32'(dbg_state), 32'(SETTLE));
    rst_n = 1'b0;
    #1;
    chk("abort_async", 32'(obs()), 32'(RST_VEC));
    @(posedge clk);
    #1;
    chk("abort_hold", 32'(obs()), 32'(RST_VEC));
    rst_n = 1'b1;
    push_powerup();
    run_n("repwr", 11);
    chk("repwr_cur", 32'(rif.cur_ratio), 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_mult_ratio_ctrl.md
Name: clk_mult_ratio_ctrl

Overview:
- Controller for the XOR-based clock-doubler chain, which produces 1x, 2x and 4x outputs.
- Sequences a glitch-safe ratio change:
  - gate the multiplied clock off,
  - hold the doubler toggle flops in reset,
  - switch the output select,
  - release reset, let the chain settle,
  - re-enable the gate.
- Runs entirely in the reference clock domain and accepts ratio-change requests via a valid/ready handshake.
- Performs an automatic power-up sequence to INIT_RATIO after reset.

Parameters:
- GATE_CYC, 4, cycles the output gate is held low before stage reset.
- RST_CYC, 2, cycles mult_rst_n is held low.
- SETTLE_CYC, 8, cycles after reset release before the gate re-opens.
- CNT_W, 4, width of the phase down-counter. Every *_CYC must be ≤ 2^CNT_W−1.
- INIT_RATIO, 2'd0, ratio applied by the power-up sequence. Encoding: 0 = 1x, 1 = 2x, 2 = 4x.

Ports:
- clk  in  1  reference clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  ratio-change request
- req_ratio  in  2  requested ratio (0 = 1x, 1 = 2x, 2 = 4x, 3 = illegal)
- req_ready  out  1  high only in IDLE
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse when a request (or the power-up sequence) completes
- err  out  1  one-cycle pulse when an illegal ratio is accepted
- cur_ratio  out  2  ratio currently in effect
- mult_sel  out  2  output-mux select for the doubler chain
- mult_rst_n  out  1  active-low reset to the doubler toggle flops
- clk_gate_en  out  1  enable for the output clock gate

Behaviour:
- All outputs are registered.
- Values while rst_n is low:
  - clk_gate_en=0, mult_rst_n=0, mult_sel=INIT_RATIO, cur_ratio=INIT_RATIO
  - done=0, err=0, req_ready=0, busy=1
  - state=RST, counter=RST_CYC
- After rst_n deasserts, the power-up sequence continues RST→SETTLE→GATE_ON→IDLE. done pulses once at the end of it.
- FSM states: IDLE, GATE_OFF, RST, SETTLE, GATE_ON.
- IDLE:
  - req_ready=1, clk_gate_en=1, mult_rst_n=1.
  - Accept on req_valid&&req_ready, then:
    - req_ratio==3: err pulses next cycle; stay IDLE; no output changes.
    - req_ratio==cur_ratio: done pulses next cycle; stay IDLE; no gating.
    - otherwise: latch the ratio into a pending register; go to GATE_OFF with counter=GATE_CYC; clk_gate_en goes 0 next cycle.
- GATE_OFF:
  - clk_gate_en=0; decrement each cycle.
  - When the counter reaches 1, next state is RST. On entry to RST: mult_sel←pending, mult_rst_n=0, counter=RST_CYC.
- RST: mult_rst_n=0. When the counter reaches 1, go to SETTLE with mult_rst_n=1 and counter=SETTLE_CYC.
- SETTLE:
  - clk_gate_en=0, mult_rst_n=1.
  - When the counter reaches 1, go to GATE_ON.
- GATE_ON:
  - Single cycle: clk_gate_en=1, cur_ratio←mult_sel, done=1.
  - Next state is IDLE.
- Latency:
  - Accept edge to done = GATE_CYC+RST_CYC+SETTLE_CYC+1 cycles (15 with defaults).
  - clk_gate_en is low for exactly GATE_CYC+RST_CYC+SETTLE_CYC cycles.
- Invariants:
  - mult_sel changes only while clk_gate_en=0 and mult_rst_n=0.
  - clk_gate_en and mult_rst_n are never both low in IDLE.
- req_valid while busy is ignored: req_ready=0 and there is no queueing. The requester must hold valid.
- A *_CYC value of 0 is treated as 1.
- rst_n asserted mid-sequence immediately forces the reset values. The power-up sequence restarts at INIT_RATIO, and the pending request is discarded.
- done and err are never high in the same cycle.

Decomposition:
- Shared package clk_mult_pkg:
  - state enum (IDLE, GATE_OFF, RST, SETTLE, GATE_ON)
  - ratio encodings RATIO_1X=0, RATIO_2X=1, RATIO_4X=2, RATIO_BAD=3
- One natural sub-module: clk_seq_timer.
  - Loadable CNT_W down-counter with load, load_val and expire outputs.
  - expire is high when count==1.
  - Instantiated once and shared across phases.

Test Plan:
- Reset release with INIT_RATIO=0:
  - mult_rst_n rises 2 cycles after release.
  - clk_gate_en rises 8 cycles after that, with a done pulse and cur_ratio=0.
  - req_ready=1 the following cycle.
- From IDLE at 1x, request ratio=2:
  - clk_gate_en low for 14 cycles; mult_rst_n low for cycles 5–6.
  - mult_sel=2 from cycle 5.
  - done at cycle 15, cur_ratio=2.
- Request ratio=3 in IDLE: err pulses 1 cycle later; mult_sel, clk_gate_en and cur_ratio are unchanged; no done.
- Request ratio equal to cur_ratio: done 1 cycle later; clk_gate_en stays 1; mult_rst_n stays 1.
- Second req_valid (ratio=1) while busy with ratio=2:
  - Ignored until IDLE.
  - If held, it is accepted the cycle after done, and a full 15-cycle sequence to 1x follows.
- Assert rst_n low during SETTLE of a change to 4x: outputs immediately return to reset values (mult_sel=INIT_RATIO), and after release the power-up sequence completes with cur_ratio=INIT_RATIO.
